count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Run controller for the 7-bit up-counter datapath (counter_7b with enable/reset).
- Turns start, pause and clear push-button levels into synchronized one-shot commands.
- Latches a clamped terminal count, gates the counter enable so counting stops exactly at the limit, and issues counter clears.
- Reports done, an optional auto-reload lap count, and FSM state for the board display logic.

Parameters:
- LIMIT_MAX, 99, ceiling applied to max_count at latch time (two-digit display limit).
- LAP_W, 4, width of the lap counter.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw button level: begin/resume counting.
- pause  input  1  raw button level: toggle pause.
- clear  input  1  raw button level: abort and zero the counter.
- max_count  input  7  requested terminal count, sampled only on accepted start.
- auto_reload  input  1  1 = restart from 0 on reaching limit, 0 = stop.
- count_in  input  7  current counter value from the datapath.
- cnt_enable  output  1  counter increment enable (combinational).
- cnt_clear  output  1  registered one-cycle counter clear.
- done  output  1  registered one-cycle pulse on run completion.
- busy  output  1  1 in RUN or PAUSE.
- laps  output  LAP_W  auto-reload completions since last start/clear, saturating.
- state_out  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; limit_q=0; laps=0; cnt_clear=0; done=0; all synchronizer and edge flops=0.
  - cnt_enable=0 and busy=0 follow from state IDLE.
- Command conditioning: each button passes through 2-flop sync → prev flop; cmd pulse = sync2 & ~prev.
  - Input sampled high at edge k gives a cmd pulse during cycle k+1..k+2, acted on at edge k+2.
  - Held buttons produce exactly one pulse.
- Priority when command pulses coincide: clear > start > pause.
- limit_q = min(max_count, LIMIT_MAX). Latched on accepted start from IDLE or DONE only.
- cnt_enable = (state==RUN) & ~cnt_clear & (count_in < limit_q).
- FSM transitions:
  - Any state + clear → IDLE; cnt_clear=1 next cycle; laps←0.
  - IDLE + start, limit==0 → DONE with done pulse; cnt_clear=1; no counting.
  - IDLE + start, limit>0 → RUN; cnt_clear=1 for one cycle; laps←0.
  - RUN + pause → PAUSE; counter holds.
  - RUN with count_in >= limit_q, auto_reload=0 → DONE; done=1 for one cycle.
  - RUN with count_in >= limit_q, auto_reload=1 → stay RUN; cnt_clear=1 for one cycle; laps+1, saturating at 2^LAP_W-1.
  - PAUSE + pause or start → RUN; limit_q not relatched.
  - DONE + start → same as IDLE + start (relatch, clear, RUN).
  - Start while in RUN → ignored.
- Boundaries:
  - count_in already above limit_q (external disturbance): treated as reached.
  - max_count>99: clamps to 99.
  - max_count changing mid-run: no effect.
  - Pause and limit reached in the same cycle: pause wins; the limit check is re-evaluated on resume.
  - Reset asserted mid-run: immediate IDLE; the counter's own reset comes from the system reset.

Decomposition:
- Shared package: state encodings (ST_IDLE/RUN/PAUSE/DONE) and LIMIT_MAX constant.
- Sub-module btn_oneshot: 2-flop sync plus rising-edge pulse, instantiated three times.

Test Plan:
- Reset release, no buttons → state_out=0, cnt_enable=0, cnt_clear=0, done=0, laps=0.
- max_count=5, auto_reload=0, press start → cnt_clear for 1 cycle, RUN; count_in reaches 5 → cnt_enable low, done single pulse, state_out=3.
- max_count=120, start → limit clamps to 99; enable drops at count_in=99.
- max_count=3, auto_reload=1, start, run 3 laps → cnt_clear pulses at each count_in=3, laps=3, busy stays 1.
- Mid-run at count 2: pause (enable 0, state 2), pause again (RUN, resumes at 2); then start and clear pressed together → clear wins, IDLE, laps=0.
- max_count=0, start → immediate DONE with done pulse; cnt_enable never asserts. Separately, hold start 20 cycles → exactly one accepted command.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count_sequencer run controller.
//   state_t     : FSM encoding, also driven out on state_out for the display
//   LIMIT_MAX_DEFAULT : two-digit display ceiling for the terminal count
//   clamp_limit : saturates a requested terminal count to a ceiling
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LIMIT_MAX_DEFAULT = 99;

  function automatic logic [6:0] clamp_limit(input logic [6:0] req,
                                             input logic [6:0] ceil);
    return (req > ceil) ? ceil : req;
  endfunction

endpackage

// File: rtl/count_sequencer_btn_oneshot.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector. A held button yields exactly one single-cycle pulse.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   i_btn   : raw asynchronous button level
//   o_pulse : one-cycle command pulse (sync2 & ~prev)
module btn_oneshot
  import count_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the 7-bit up-counter datapath.
// Conditions start/pause/clear buttons into one-shot commands, latches a
// clamped terminal count, gates the counter enable so counting stops exactly
// at the limit, and issues counter clears.
//   clk, reset   : clock, asynchronous active-low reset
//   start/pause/clear : raw button levels
//   max_count    : requested terminal count (sampled on accepted start)
//   auto_reload  : 1 = restart from 0 at the limit, 0 = stop
//   count_in     : current counter value from the datapath
//   cnt_enable   : counter increment enable (combinational)
//   cnt_clear    : registered one-cycle counter clear
//   done         : registered one-cycle completion pulse
//   busy         : high in RUN or PAUSE
//   laps         : saturating auto-reload completion count
//   state_out    : IDLE=0, RUN=1, PAUSE=2, DONE=3
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int LIMIT_MAX = LIMIT_MAX_DEFAULT,
  parameter int LAP_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [6:0]       max_count,
  input  logic             auto_reload,
  input  logic [6:0]       count_in,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             done,
  output logic             busy,
  output logic [LAP_W-1:0] laps,
  output logic [1:0]       state_out
);

  localparam logic [6:0]       LIMIT_CEIL = 7'(LIMIT_MAX);
  localparam logic [LAP_W-1:0] LAPS_SAT   = '1;

  logic w_start;
  logic w_pause;
  logic w_clr;

  btn_oneshot u_start (.clk(clk), .rst_n(reset), .i_btn(start), .o_pulse(w_start));
  btn_oneshot u_pause (.clk(clk), .rst_n(reset), .i_btn(pause), .o_pulse(w_pause));
  btn_oneshot u_clear (.clk(clk), .rst_n(reset), .i_btn(clear), .o_pulse(w_clr));

  state_t           r_state;
  logic [6:0]       r_limit;
  logic [LAP_W-1:0] r_laps;
  logic             r_cnt_clear;
  logic             r_done;

  logic [6:0] w_limit_new;
  logic       w_at_limit;

  assign w_limit_new = clamp_limit(max_count, LIMIT_CEIL);
  // ">=" so a counter disturbed past the limit still terminates the run.
  assign w_at_limit  = (count_in >= r_limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_limit     <= '0;
      r_laps      <= '0;
      r_cnt_clear <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt_clear <= 1'b0;
      r_done      <= 1'b0;
      if (w_clr) begin
        r_state     <= ST_IDLE;
        r_cnt_clear <= 1'b1;
        r_laps      <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_start) begin
              r_limit     <= w_limit_new;
              r_cnt_clear <= 1'b1;
              r_laps      <= '0;
              if (w_limit_new == 7'd0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            // While a clear is in flight count_in still shows the stale
            // value, so the limit check waits until the clear has landed.
            if (w_pause) begin
              r_state <= ST_PAUSE;
            end else if (!r_cnt_clear && w_at_limit) begin
              if (auto_reload) begin
                r_cnt_clear <= 1'b1;
                if (r_laps != LAPS_SAT) r_laps <= r_laps + 1'b1;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (w_pause || w_start) r_state <= ST_RUN;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cnt_enable = (r_state == ST_RUN) & ~r_cnt_clear & ~w_at_limit;
  assign cnt_clear  = r_cnt_clear;
  assign done       = r_done;
  assign busy       = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign laps       = r_laps;
  assign state_out  = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer. A small behavioural 7-bit counter
// stands in for the datapath; count_in can be overridden to inject a
// disturbance.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, clear;
  logic [6:0] max_count;
  logic       auto_reload;
  logic [6:0] count_in;
  logic       cnt_enable, cnt_clear, done, busy;
  logic [3:0] laps;
  logic [1:0] state_out;

  logic [6:0] r_cnt;
  logic       force_en;
  logic [6:0] force_val;

  int checks = 0;
  int errors = 0;
  int done_seen;

  count_sequencer #(.LIMIT_MAX(99), .LAP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .max_count(max_count), .auto_reload(auto_reload), .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .done(done), .busy(busy),
    .laps(laps), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: clear has priority over enable.
  always @(posedge clk or negedge reset) begin
    if (!reset)          r_cnt <= 7'd0;
    else if (cnt_clear)  r_cnt <= 7'd0;
    else if (cnt_enable) r_cnt <= r_cnt + 7'd1;
  end
  assign count_in = force_en ? force_val : r_cnt;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle press; returns just after the edge where the command is acted on.
  task automatic press(input logic s, input logic p, input logic c);
    start = s; pause = p; clear = c;
    tick(1);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    max_count = 7'd0; auto_reload = 1'b0; force_en = 1'b0; force_val = 7'd0;
    tick(3);
    reset = 1'b1;
    tick(3);

    // Reset state
    chk("rst_state", state_out, 0);
    chk("rst_enable", cnt_enable, 0);
    chk("rst_clear", cnt_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_laps", laps, 0);
    chk("rst_busy", busy, 0);

    // Limit 5, stop mode; max_count changed mid-run must be ignored
    max_count = 7'd5;
    start = 1'b1; tick(1); start = 1'b0; tick(1);
    chk("s5_not_yet", state_out, 0);
    tick(1);
    chk("s5_run", state_out, 1);
    chk("s5_clr", cnt_clear, 1);
    chk("s5_en_during_clr", cnt_enable, 0);
    chk("s5_busy", busy, 1);
    max_count = 7'd50;
    tick(1);
    chk("s5_clr_one_cycle", cnt_clear, 0);
    chk("s5_cnt0", count_in, 0);
    chk("s5_en", cnt_enable, 1);
    tick(5);
    chk("s5_cnt5", count_in, 5);
    chk("s5_en_off", cnt_enable, 0);
    chk("s5_no_done_yet", done, 0);
    tick(1);
    chk("s5_done_state", state_out, 3);
    chk("s5_done_pulse", done, 1);
    tick(1);
    chk("s5_done_single", done, 0);
    chk("s5_hold5", count_in, 5);

    // Clamp: request 120, limit becomes 99
    max_count = 7'd120;
    press(1'b1, 1'b0, 1'b0);
    chk("c99_run", state_out, 1);
    tick(1);
    chk("c99_cnt0", count_in, 0);
    tick(98);
    chk("c99_cnt98", count_in, 98);
    chk("c99_en98", cnt_enable, 1);
    tick(1);
    chk("c99_cnt99", count_in, 99);
    chk("c99_en99", cnt_enable, 0);
    tick(1);
    chk("c99_done", done, 1);

    // Auto-reload, limit 3: lap every 5 cycles
    max_count = 7'd3; auto_reload = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    chk("ar_laps0", laps, 0);
    tick(4);
    chk("ar_cnt3", count_in, 3);
    chk("ar_en_off", cnt_enable, 0);
    tick(1);
    chk("ar_lap1_clr", cnt_clear, 1);
    chk("ar_lap1", laps, 1);
    chk("ar_lap1_state", state_out, 1);
    tick(5);
    chk("ar_lap2_clr", cnt_clear, 1);
    chk("ar_lap2", laps, 2);
    tick(5);
    chk("ar_lap3_clr", cnt_clear, 1);
    chk("ar_lap3", laps, 3);
    chk("ar_busy", busy, 1);
    press(1'b0, 1'b0, 1'b1);
    chk("ar_clear_state", state_out, 0);
    chk("ar_clear_laps", laps, 0);
    chk("ar_clear_clr", cnt_clear, 1);

    // Pause at count 2, resume, then start+clear together
    max_count = 7'd10; auto_reload = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    pause = 1'b1; tick(1); pause = 1'b0; tick(2);
    chk("pz_state", state_out, 2);
    chk("pz_cnt2", count_in, 2);
    chk("pz_en", cnt_enable, 0);
    chk("pz_busy", busy, 1);
    tick(3);
    chk("pz_hold", count_in, 2);
    press(1'b0, 1'b1, 1'b0);
    chk("pz_resume", state_out, 1);
    chk("pz_resume_cnt", count_in, 2);
    chk("pz_resume_en", cnt_enable, 1);
    press(1'b1, 1'b0, 1'b1);
    chk("sc_state", state_out, 0);
    chk("sc_busy", busy, 0);
    chk("sc_laps", laps, 0);

    // Limit 0: immediate DONE, no counting
    max_count = 7'd0;
    press(1'b1, 1'b0, 1'b0);
    chk("z_state", state_out, 3);
    chk("z_done", done, 1);
    chk("z_clr", cnt_clear, 1);
    for (int i = 0; i < 4; i++) begin
      chk("z_en_never", cnt_enable, 0);
      tick(1);
    end
    chk("z_done_single", done, 0);

    // Held start: exactly one accepted command
    done_seen = 0;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) start = 1'b0;
      tick(1);
      if (done) done_seen++;
    end
    chk("hold_one_cmd", done_seen, 1);

    // count_in disturbed above limit counts as reached
    max_count = 7'd10;
    press(1'b1, 1'b0, 1'b0);
    tick(1);
    force_en = 1'b1; force_val = 7'd50;
    #1;
    chk("dist_en", cnt_enable, 0);
    tick(1);
    chk("dist_done", done, 1);
    chk("dist_state", state_out, 3);
    force_en = 1'b0;

    // start+clear in DONE: clear wins
    press(1'b1, 1'b0, 1'b1);
    chk("dsc_state", state_out, 0);
    chk("dsc_clr", cnt_clear, 1);

    // Asynchronous reset mid-run
    press(1'b1, 1'b0, 1'b0);
    tick(3);
    chk("ar_pre_run", state_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", state_out, 0);
    chk("async_busy", busy, 0);
    chk("async_en", cnt_enable, 0);
    reset = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
